mod_counter: RTL
================

# mod_counter

Parametrised, loadable up/down counter with a programmable terminal value, wrap or one-shot mode, and registered wrap/done status. It is the general counting primitive for the modulation datapath: symbol/sample period timers, carrier phase steps and PWM frame counters. It replaces fixed-width free-running counters wherever a period shorter than 2^WIDTH, down-counting, or stop-at-terminal behaviour is needed.

## Interface
- WIDTH, default 6: counter, load, period and compare width (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cnt_en  in  1  advance counter by one step this cycle.
- init  in  1  load `ld` into `out`; also leaves HOLD and clears `done`.
- ld  in  WIDTH  load value.
- period  in  WIDTH  terminal value; count range is 0..period.
- dir  in  1  0 = count up, 1 = count down.
- one_shot  in  1  0 = wrap at terminal, 1 = stop at terminal.
- out  out  WIDTH  current count (registered).
- co  out  1  combinational terminal flag: up → `out >= period`; down → `out == 0`.
- wrap  out  1  registered one-cycle pulse: terminal step taken.
- done  out  1  registered sticky flag: one-shot run finished.
- cmp  in  WIDTH  compare threshold (only with MOD_COUNTER_CMP_EN).
- pwm  out  1  registered compare output (only with MOD_COUNTER_CMP_EN).

## Operation
- Two states: COUNT, HOLD. Reset → COUNT, out=0, wrap=0, done=0, pwm=0.
- Priority per edge: rst > init > cnt_en > hold value.
- init (either state): out←ld, state←COUNT, done←0, wrap←0. cnt_en ignored that cycle.
- COUNT, cnt_en=1, co=0: up → out+1; down → out−1. wrap←0.
- COUNT, cnt_en=1, co=1, one_shot=0: up → out←0; down → out←period. wrap←1.
- COUNT, cnt_en=1, co=1, one_shot=1: out unchanged, state←HOLD, done←1, wrap←1.
- COUNT, cnt_en=0: out unchanged, wrap←0.
- HOLD: out, done held; wrap←0; cnt_en, dir, period, one_shot ignored; exit only via init or rst.
- Out-of-range values (out > period after ld or period change): up → co=1, next enabled step goes to 0 (or HOLD); down → counts down normally to 0.
- period=0: up mode out stays 0, co=1 permanently, wrap pulses on every enabled cycle. Down mode identical.
- dir may change any cycle; takes effect on that cycle's step using current `out`. No extra latency.
- All arithmetic modulo 2^WIDTH; no overflow beyond wrap rules above.

## Timing
- Single step latency: inputs sampled at edge N; `out` reflects the step in cycle N+1.
- co is combinational from `out`/`period`/`dir` (same cycle).
- wrap is high in exactly cycle N+1 after a terminal step at edge N, coincident with the wrapped `out` value; never high two cycles in a row unless terminal steps are consecutive (period=0).
- done rises with wrap on the one-shot terminal step; stays high until init/rst.
- rst mid-run: next cycle out=0, COUNT, all flags 0, regardless of other inputs.

## Configuration
- MOD_COUNTER_CMP_EN defined: ports `cmp` and `pwm` exist; every edge pwm←(out < cmp) using pre-edge `out`, i.e. pwm lags `out` by one cycle; updated in both states and regardless of cnt_en; rst→0, init does not affect pwm.
- Not defined: `cmp`/`pwm` ports and logic absent; all other behaviour identical.

## Test plan
- Reset then up count, WIDTH=6, period=5, one_shot=0, cnt_en=1: out 0,1,2,3,4,5,0,1…; co high when out=5; wrap high only in cycles with out=0 following 5.
- Down count, period=5, init with ld=2, dir=1: out 2,1,0,5,4…; co high at out=0; wrap pulse with out=5.
- One-shot up, period=3: out 0,1,2,3 then held at 3; done and wrap rise together; wrap drops next cycle, done stays; cnt_en toggling has no effect; init ld=0 → out=0, done=0, counting resumes.
- Out-of-range: period=10, init ld=40, up: co=1, next enabled step out=0 with wrap=1; same with dir=1 → 39,38…
- Priority/simultaneity: rst+init+cnt_en same edge → out=0; init+cnt_en with ld=7 → out=7, not 8; dir flip mid-count at out=3 → next out=2.
- With MOD_COUNTER_CMP_EN, period=7, cmp=3, free run: pwm high 3 of every 8 cycles, one cycle after out=0,1,2; cmp=0 → pwm constantly 0; cmp=63, period=7 → constantly 1.

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: loadable up/down counter with terminal value, wrap/one-shot modes and wrap/done status.
// Optional compare/PWM output enabled by defining MOD_COUNTER_CMP_EN.
module mod_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             init,
  input  logic [WIDTH-1:0] ld,
  input  logic [WIDTH-1:0] period,
  input  logic             dir,
  input  logic             one_shot,
`ifdef MOD_COUNTER_CMP_EN
  input  logic [WIDTH-1:0] cmp,
  output logic             pwm,
`endif
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             wrap,
  output logic             done
);
  typedef enum logic {COUNT, HOLD} state_t;
  state_t state;
  logic [WIDTH-1:0] step, term;
  always_comb begin
    co   = dir ? (out == '0) : (out >= period);
    step = dir ? out - 1'b1 : out + 1'b1;
    term = dir ? period : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COUNT;
      out   <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else if (init) begin
      state <= COUNT;
      out   <= ld;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else if (state == COUNT && cnt_en) begin
      wrap <= co;
      if (!co) out <= step;
      else if (!one_shot) out <= term;
      else begin
        state <= HOLD;
        done  <= 1'b1;
      end
    end else begin
      wrap <= 1'b0;
    end
  end
`ifdef MOD_COUNTER_CMP_EN
  always_ff @(posedge clk) pwm <= rst ? 1'b0 : (out < cmp);
`endif
endmodule
